// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the ALU issue controller: RV32I/E
//               opcode constants, 5-bit ALU operation encodings and the
//               issue FSM state type.
//               ALU op layout is {is_branch, funct7_5 (gated), funct3}.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Major opcodes accepted by the controller (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Arithmetic / logic operations
    localparam logic [4:0] ALU_OP_ADD  = 5'b00000;
    localparam logic [4:0] ALU_OP_SLL  = 5'b00001;
    localparam logic [4:0] ALU_OP_SLT  = 5'b00010;
    localparam logic [4:0] ALU_OP_SLTU = 5'b00011;
    localparam logic [4:0] ALU_OP_XOR  = 5'b00100;
    localparam logic [4:0] ALU_OP_SRL  = 5'b00101;
    localparam logic [4:0] ALU_OP_OR   = 5'b00110;
    localparam logic [4:0] ALU_OP_AND  = 5'b00111;
    localparam logic [4:0] ALU_OP_SUB  = 5'b01000;
    localparam logic [4:0] ALU_OP_SRA  = 5'b01101;

    // Branch comparisons (result bit0 = taken)
    localparam logic [4:0] ALU_OP_BEQ  = 5'b10000;
    localparam logic [4:0] ALU_OP_BNE  = 5'b10001;
    localparam logic [4:0] ALU_OP_BLT  = 5'b10100;
    localparam logic [4:0] ALU_OP_BGE  = 5'b10101;
    localparam logic [4:0] ALU_OP_BLTU = 5'b10110;
    localparam logic [4:0] ALU_OP_BGEU = 5'b10111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } issue_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational decode of opcode/funct3/funct7_5 into the
//               5-bit ALU operation, operand-B select and a supported flag.
// Ports       : i_opcode    [6:0]  instr[6:0]
//               i_funct3    [2:0]  instr[14:12]
//               i_funct7_5         instr[30]
//               o_alu_op    [4:0]  {is_branch, funct7_5 gated, funct3}
//               o_use_imm          operand B comes from the immediate
//               o_supported        opcode is OP, OP-IMM or BRANCH
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [4:0] o_alu_op,
    output logic       o_use_imm,
    output logic       o_supported
);

    always_comb begin
        o_alu_op    = ALU_OP_ADD;
        o_use_imm   = 1'b0;
        o_supported = 1'b0;
        case (i_opcode)
            OPC_OP: begin
                o_alu_op    = {1'b0, i_funct7_5, i_funct3};
                o_supported = 1'b1;
            end
            OPC_OP_IMM: begin
                // In OP-IMM, instr[30] is immediate data except for SRAI,
                // so it only selects the arithmetic shift.
                o_alu_op    = {1'b0, (i_funct3 == 3'b101) & i_funct7_5, i_funct3};
                o_use_imm   = 1'b1;
                o_supported = 1'b1;
            end
            OPC_BRANCH: begin
                o_alu_op    = {2'b10, i_funct3};
                o_supported = 1'b1;
            end
            default: begin
                o_alu_op    = ALU_OP_ADD;
                o_use_imm   = 1'b0;
                o_supported = 1'b0;
            end
        endcase
    end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Initiator side of the ALU available/busy/fault handshake.
//               Takes one decoded instruction on a valid/ready port, issues
//               it to the ALU and holds operands until the unit completes,
//               then presents result/fault and the pass-through tag.
// Ports       : clk, reset_n (synchronous, active low)
//               req_*   : instruction request (valid/ready)
//               alu_*   : ALU handshake (available out; busy/fault/out in)
//               res_*   : result channel (valid/ready, data, fault, tag)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int TAG_W       = 5,
    parameter int TIMEOUT_CYC = 15
)
(
    input  logic             clk,
    input  logic             reset_n,
    // request from decode
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_opcode,
    input  logic [2:0]       req_funct3,
    input  logic             req_funct7_5,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [31:0]      req_imm,
    input  logic [TAG_W-1:0] req_tag,
    // ALU handshake
    output logic             alu_available,
    output logic [4:0]       alu_op,
    output logic [31:0]      alu_in_a,
    output logic [31:0]      alu_in_b,
    input  logic [31:0]      alu_out,
    input  logic             alu_busy,
    input  logic             alu_fault,
    // result to downstream
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_fault,
    output logic [TAG_W-1:0] res_tag
);

    localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    issue_state_t       r_state,     w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic               r_avail,     w_avail_nxt;
    logic [4:0]         r_op,        w_op_nxt;
    logic [31:0]        r_in_a,      w_in_a_nxt;
    logic [31:0]        r_in_b,      w_in_b_nxt;
    logic [TAG_W-1:0]   r_tag,       w_tag_nxt;
    logic               r_res_valid, w_res_valid_nxt;
    logic [31:0]        r_res_data,  w_res_data_nxt;
    logic               r_res_fault, w_res_fault_nxt;

    logic [4:0]         w_dec_op;
    logic               w_dec_use_imm;
    logic               w_dec_supported;
    logic [c_CNT_W-1:0] w_cnt_inc;

    alu_op_decode u_decode (
        .i_opcode    (req_opcode),
        .i_funct3    (req_funct3),
        .i_funct7_5  (req_funct7_5),
        .o_alu_op    (w_dec_op),
        .o_use_imm   (w_dec_use_imm),
        .o_supported (w_dec_supported)
    );

    assign w_cnt_inc = r_cnt + c_CNT_ONE;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_avail_nxt     = r_avail;
        w_op_nxt        = r_op;
        w_in_a_nxt      = r_in_a;
        w_in_b_nxt      = r_in_b;
        w_tag_nxt       = r_tag;
        w_res_valid_nxt = r_res_valid;
        w_res_data_nxt  = r_res_data;
        w_res_fault_nxt = r_res_fault;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_tag_nxt = req_tag;
                    w_cnt_nxt = '0;
                    if (w_dec_supported) begin
                        w_state_nxt     = ISSUE;
                        w_avail_nxt     = 1'b1;
                        w_op_nxt        = w_dec_op;
                        w_in_a_nxt      = req_rs1;
                        w_in_b_nxt      = w_dec_use_imm ? req_imm : req_rs2;
                        w_res_data_nxt  = '0;
                        w_res_fault_nxt = 1'b0;
                    end else begin
                        // Unsupported opcode: answer immediately, ALU untouched.
                        w_state_nxt     = DONE;
                        w_res_valid_nxt = 1'b1;
                        w_res_data_nxt  = '0;
                        w_res_fault_nxt = 1'b1;
                    end
                end
            end

            ISSUE: begin
                w_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc >= c_TIMEOUT) begin
                    w_state_nxt     = DONE;
                    w_avail_nxt     = 1'b0;
                    w_res_valid_nxt = 1'b1;
                    w_res_data_nxt  = '0;
                    w_res_fault_nxt = 1'b1;
                end else if (alu_busy) begin
                    w_state_nxt = WAIT;
                end
            end

            WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                // A genuine completion wins over a timeout landing on the same cycle.
                if (!alu_busy) begin
                    w_state_nxt     = DONE;
                    w_avail_nxt     = 1'b0;
                    w_res_valid_nxt = 1'b1;
                    w_res_data_nxt  = alu_out;
                    w_res_fault_nxt = alu_fault;
                end else if (w_cnt_inc >= c_TIMEOUT) begin
                    w_state_nxt     = DONE;
                    w_avail_nxt     = 1'b0;
                    w_res_valid_nxt = 1'b1;
                    w_res_data_nxt  = '0;
                    w_res_fault_nxt = 1'b1;
                end
            end

            DONE: begin
                // Going through IDLE keeps available low for at least one
                // cycle and stops a request being taken on the completing edge.
                w_avail_nxt = 1'b0;
                if (res_ready) begin
                    w_state_nxt     = IDLE;
                    w_res_valid_nxt = 1'b0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_avail_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_avail     <= 1'b0;
            r_op        <= '0;
            r_in_a      <= '0;
            r_in_b      <= '0;
            r_tag       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_fault <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_avail     <= w_avail_nxt;
            r_op        <= w_op_nxt;
            r_in_a      <= w_in_a_nxt;
            r_in_b      <= w_in_b_nxt;
            r_tag       <= w_tag_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_fault <= w_res_fault_nxt;
        end
    end

    assign req_ready     = (r_state == IDLE);
    assign alu_available = r_avail;
    assign alu_op        = r_op;
    assign alu_in_a      = r_in_a;
    assign alu_in_b      = r_in_b;
    assign res_valid     = r_res_valid;
    assign res_data      = r_res_data;
    assign res_fault     = r_res_fault;
    assign res_tag       = r_tag;

endmodule : alu_issue_ctrl
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Directed self-checking bench for alu_issue_ctrl with a
//               registered ALU model (busy rises one edge after available,
//               result one edge later) and a stuck-busy mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [6:0]       req_opcode;
    logic [2:0]       req_funct3;
    logic             req_funct7_5;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [31:0]      req_imm;
    logic [TAG_W-1:0] req_tag;
    logic             alu_available;
    logic [4:0]       alu_op;
    logic [31:0]      alu_in_a;
    logic [31:0]      alu_in_b;
    logic [31:0]      alu_out;
    logic             alu_busy;
    logic             alu_fault;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic             res_fault;
    logic [TAG_W-1:0] res_tag;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYC(15)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opcode    (req_opcode),
        .req_funct3    (req_funct3),
        .req_funct7_5  (req_funct7_5),
        .req_rs1       (req_rs1),
        .req_rs2       (req_rs2),
        .req_imm       (req_imm),
        .req_tag       (req_tag),
        .alu_available (alu_available),
        .alu_op        (alu_op),
        .alu_in_a      (alu_in_a),
        .alu_in_b      (alu_in_b),
        .alu_out       (alu_out),
        .alu_busy      (alu_busy),
        .alu_fault     (alu_fault),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_fault     (res_fault),
        .res_tag       (res_tag)
    );

    // ---------------- ALU model ----------------
    logic [1:0]  m_phase = 2'd0;
    logic        m_busy  = 1'b0;
    logic        m_stuck = 1'b0;
    logic [31:0] m_out   = 32'd0;

    function automatic logic [31:0] alu_calc(input logic [4:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            5'b00000: return a + b;
            5'b01000: return a - b;
            5'b00001: return a << b[4:0];
            5'b00010: return {31'd0, $signed(a) < $signed(b)};
            5'b00011: return {31'd0, a < b};
            5'b00100: return a ^ b;
            5'b00101: return a >> b[4:0];
            5'b01101: return $unsigned($signed(a) >>> b[4:0]);
            5'b00110: return a | b;
            5'b00111: return a & b;
            5'b10000: return {31'd0, a == b};
            5'b10001: return {31'd0, a != b};
            5'b10100: return {31'd0, $signed(a) < $signed(b)};
            5'b10101: return {31'd0, $signed(a) >= $signed(b)};
            5'b10110: return {31'd0, a < b};
            5'b10111: return {31'd0, a >= b};
            default:  return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!alu_available) begin
            m_phase <= 2'd0;
            m_busy  <= 1'b0;
        end else if (m_phase == 2'd0) begin
            m_phase <= 2'd1;
            m_busy  <= 1'b1;
        end else if (m_phase == 2'd1) begin
            m_phase <= 2'd2;
            m_busy  <= 1'b0;
            m_out   <= alu_calc(alu_op, alu_in_a, alu_in_b);
        end
    end

    assign alu_busy  = m_busy | m_stuck;
    assign alu_out   = m_out;
    assign alu_fault = 1'b0;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic [TAG_W-1:0] tag);
        req_opcode   = opc;
        req_funct3   = f3;
        req_funct7_5 = f7;
        req_rs1      = a;
        req_rs2      = b;
        req_imm      = imm;
        req_tag      = tag;
        req_valid    = 1'b1;
    endtask

    // Issue one supported op and wait for its result. Expects res_valid on the
    // third edge after the accepting edge.
    task automatic run_op(input string name, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [TAG_W-1:0] tag,
                          input logic [4:0] exp_op, input logic [31:0] exp_b,
                          input logic [31:0] exp_data);
        int n;
        drive_req(opc, f3, f7, a, b, imm, tag);
        tick();
        req_valid = 1'b0;
        req_rs1   = ~a;          // operands must not follow the request bus
        req_rs2   = ~b;
        req_imm   = ~imm;
        chk({name, ".avail"}, {31'd0, alu_available}, 32'd1);
        chk({name, ".op"},    {27'd0, alu_op}, {27'd0, exp_op});
        chk({name, ".b"},     alu_in_b, exp_b);
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        chk({name, ".lat"},   n, 3);
        chk({name, ".hold_a"}, alu_in_a, a);
        chk({name, ".data"},  res_data, exp_data);
        chk({name, ".fault"}, {31'd0, res_fault}, 32'd0);
        chk({name, ".tag"},   {27'd0, res_tag}, {27'd0, tag});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_opcode   = '0;
        req_funct3   = '0;
        req_funct7_5 = 1'b0;
        req_rs1      = '0;
        req_rs2      = '0;
        req_imm      = '0;
        req_tag      = '0;
        res_ready    = 1'b1;
        tick();
        tick();
        chk("rst.avail", {31'd0, alu_available}, 32'd0);
        chk("rst.valid", {31'd0, res_valid}, 32'd0);
        chk("rst.ready", {31'd0, req_ready}, 32'd1);
        chk("rst.data",  res_data, 32'd0);
        reset_n = 1'b1;
        tick();

        // ADDI with instr[30] set must still be an add
        run_op("addi", 7'b0010011, 3'b000, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFF9, 5'd1,
               5'b00000, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        tick();
        chk("addi.idle", {31'd0, req_ready}, 32'd1);

        run_op("sub", 7'b0110011, 3'b000, 1'b1, 32'd3, 32'd10, 32'd0, 5'd2,
               5'b01000, 32'd10, 32'hFFFF_FFF9);
        tick();

        run_op("srai", 7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 5'd3,
               5'b01101, 32'd4, 32'hF800_0000);
        tick();

        // BLTU with downstream stalled for 5 cycles
        res_ready = 1'b0;
        run_op("bltu", 7'b1100011, 3'b110, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd4,
               5'b10110, 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall.valid", {31'd0, res_valid}, 32'd1);
            chk("stall.data",  res_data, 32'd1);
            chk("stall.ready", {31'd0, req_ready}, 32'd0);
        end

        // Request offered on the completing edge must wait for IDLE
        drive_req(7'b0110011, 3'b000, 1'b0, 32'd2, 32'd3, 32'd0, 5'd5);
        res_ready = 1'b1;
        tick();
        chk("nooverlap.ready", {31'd0, req_ready}, 32'd1);
        chk("nooverlap.avail", {31'd0, alu_available}, 32'd0);
        tick();
        req_valid = 1'b0;
        chk("next.avail", {31'd0, alu_available}, 32'd1);
        begin
            int n;
            n = 0;
            while (!res_valid && n < 20) begin
                tick();
                n++;
            end
            chk("next.lat",  n, 3);
            chk("next.data", res_data, 32'd5);
        end
        tick();

        // Unsupported opcode (LOAD)
        drive_req(7'b0000011, 3'b010, 1'b0, 32'd1, 32'd2, 32'd3, 5'd7);
        tick();
        req_valid = 1'b0;
        chk("unsup.valid", {31'd0, res_valid}, 32'd1);
        chk("unsup.fault", {31'd0, res_fault}, 32'd1);
        chk("unsup.data",  res_data, 32'd0);
        chk("unsup.tag",   {27'd0, res_tag}, 32'd7);
        chk("unsup.avail", {31'd0, alu_available}, 32'd0);
        tick();
        chk("unsup.avail2", {31'd0, alu_available}, 32'd0);
        chk("unsup.idle",   {31'd0, req_ready}, 32'd1);

        // Timeout with busy stuck high
        m_stuck = 1'b1;
        drive_req(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 5'd8);
        tick();
        req_valid = 1'b0;
        repeat (14) tick();
        chk("tmo.pre_valid", {31'd0, res_valid}, 32'd0);
        chk("tmo.pre_avail", {31'd0, alu_available}, 32'd1);
        tick();
        chk("tmo.valid", {31'd0, res_valid}, 32'd1);
        chk("tmo.fault", {31'd0, res_fault}, 32'd1);
        chk("tmo.data",  res_data, 32'd0);
        chk("tmo.avail", {31'd0, alu_available}, 32'd0);
        tick();

        // Reset in the middle of WAIT
        drive_req(7'b0110011, 3'b111, 1'b0, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'd0, 5'd9);
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        chk("mid.avail_pre", {31'd0, alu_available}, 32'd1);
        reset_n = 1'b0;
        tick();
        chk("mid.avail", {31'd0, alu_available}, 32'd0);
        chk("mid.op",    {27'd0, alu_op}, 32'd0);
        chk("mid.a",     alu_in_a, 32'd0);
        chk("mid.b",     alu_in_b, 32'd0);
        chk("mid.tag",   {27'd0, res_tag}, 32'd0);
        chk("mid.valid", {31'd0, res_valid}, 32'd0);
        chk("mid.fault", {31'd0, res_fault}, 32'd0);
        chk("mid.ready", {31'd0, req_ready}, 32'd1);
        reset_n = 1'b1;
        m_stuck = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_alu_issue_ctrl
`default_nettype wire
